upec_output_miter: RTL

//  Downstream checker for the dual-instance Earlgrey UPEC harness. Takes the concatenated pad

---
 rtl/upec_miter_pkg.sv | 14 +
 rtl/upec_sat_counter.sv | 33 +++
 rtl/upec_output_miter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/upec_miter_pkg.sv
// Shared types and default widths for the UPEC output miter.
package upec_miter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        COMPARE  = 2'd2,
        DIVERGED = 2'd3
    } miter_state_e;

    localparam int unsigned UpecObsWidth = 142;
    localparam int unsigned UpecCntWidth = 32;

endpackage

// File: rtl/upec_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module upec_sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/upec_output_miter.sv
// Masked compare of two instances' pad outputs with a sticky first-divergence verdict.
// Define UPEC_MITER_INPUT_REG_EN to register operands and mask ahead of the compare stage.
//
// state    | meaning
// IDLE     | waiting for arm_i
// SETTLE   | settle window after arm, no compares
// COMPARE  | comparing every cycle, cmp_count_o advancing
// DIVERGED | first divergence captured, everything frozen until clear/reset
module upec_output_miter
    import upec_miter_pkg::*;
#(
    parameter int unsigned Width        = UpecObsWidth,
    parameter int unsigned CntWidth     = UpecCntWidth,
    parameter int unsigned SettleCycles = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                arm_i,
    input  logic                clear_i,
    input  logic [Width-1:0]    obs_a_i,
    input  logic [Width-1:0]    obs_b_i,
    input  logic [Width-1:0]    mask_i,
    output logic [1:0]          state_o,
    output logic                comparing_o,
    output logic                diverged_o,
    output logic [Width-1:0]    first_diff_o,
    output logic [CntWidth-1:0] div_cycle_o,
    output logic [CntWidth-1:0] cmp_count_o
);

    localparam int unsigned SetW        = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam int unsigned SettleLoadI = (SettleCycles > 0) ? SettleCycles - 1 : 0;
    localparam logic [SetW-1:0] SettleLoad = SetW'(SettleLoadI);

    miter_state_e        state_q;
    logic [SetW-1:0]     settle_q;
    logic                diverged_q;
    logic [Width-1:0]    first_diff_q;
    logic [CntWidth-1:0] div_cycle_q;
    logic [CntWidth-1:0] cmp_count;

    logic [Width-1:0] cmp_a, cmp_b, cmp_m;
    logic [Width-1:0] diff;

`ifdef UPEC_MITER_INPUT_REG_EN
    logic [Width-1:0] obs_a_q, obs_b_q, mask_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            obs_a_q <= '0;
            obs_b_q <= '0;
            mask_q  <= '0;
        end else begin
            obs_a_q <= obs_a_i;
            obs_b_q <= obs_b_i;
            mask_q  <= mask_i;
        end
    end

    assign cmp_a = obs_a_q;
    assign cmp_b = obs_b_q;
    assign cmp_m = mask_q;
`else
    assign cmp_a = obs_a_i;
    assign cmp_b = obs_b_i;
    assign cmp_m = mask_i;
`endif

    assign diff = (cmp_a ^ cmp_b) & ~cmp_m;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            diverged_q   <= 1'b0;
            first_diff_q <= '0;
            div_cycle_q  <= '0;
        end else if (clear_i) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            diverged_q   <= 1'b0;
            first_diff_q <= '0;
            div_cycle_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm_i) begin
                        if (SettleCycles == 0) begin
                            state_q <= COMPARE;
                        end else begin
                            state_q  <= SETTLE;
                            settle_q <= SettleLoad;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= COMPARE;
                    end else begin
                        settle_q <= settle_q - SetW'(1);
                    end
                end
                COMPARE: begin
                    // Index captured is the pre-increment count of this same edge.
                    if (|diff) begin
                        state_q      <= DIVERGED;
                        diverged_q   <= 1'b1;
                        first_diff_q <= diff;
                        div_cycle_q  <= cmp_count;
                    end
                end
                DIVERGED: begin
                    state_q <= DIVERGED;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    upec_sat_counter #(
        .Width (CntWidth)
    ) u_cmp_count (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   ((state_q == IDLE) && arm_i && !clear_i),
        .en_i    ((state_q == COMPARE) && !clear_i),
        .count_o (cmp_count)
    );

    assign state_o      = state_q;
    assign comparing_o  = (state_q == COMPARE);
    assign diverged_o   = diverged_q;
    assign first_diff_o = first_diff_q;
    assign div_cycle_o  = div_cycle_q;
    assign cmp_count_o  = cmp_count;

endmodule
